program_mem_server: RTL and testbench

- Responder end of the program-memory read handshake driven by each core's instruction fetcher.
- Serves NUM_CONSUMERS fetchers from one single-ported program store, with round-robin arbitration and a configurable access latency.
- Includes a host load port that writes the kernel into the store before launch.
- Sits between the per-core fetchers and the program memory, in place of an external memory model.

---
 rtl/gpu_mem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/program_mem_server.sv | 121 ++++++++++++
 tb/tb_program_mem_server.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory-side servers.
// - srv_state_e : server FSM encoding (IDLE/ACCESS/RELAY)
// - DEF_*_BITS  : default widths, kept in step with the fetcher parameters
// - idx_bits()  : width of an index into n channels (never less than 1)
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RELAY  = 2'b10
    } srv_state_e;

    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 16;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans req starting at ptr, wrapping modulo N, and reports the first set bit.
// Ports:
//   req : request vector
//   ptr : highest-priority channel this cycle
//   gnt : one-hot grant (all zero when no request)
//   idx : encoded grant index (0 when no request)
//   hit : any request present
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          hit
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/program_mem_server.sv
// Program-memory responder for NUM_CONSUMERS instruction fetchers.
// One single-ported store, one access in flight, round-robin between fetchers.
// The store is never cleared; the host load port may write it at any edge,
// including during reset.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   consumer_read_valid    : per-fetcher request strobe
//   consumer_read_address  : packed request addresses, slice i = consumer i
//   consumer_read_ready    : per-fetcher response strobe
//   consumer_read_data     : packed response data, slice i = consumer i
//   load_valid/address/data: host write port
//   busy                   : server not in IDLE
module program_mem_server
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int LATENCY       = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic                               load_valid,
    input  logic [ADDR_BITS-1:0]               load_address,
    input  logic [DATA_BITS-1:0]               load_data,
    output logic                               busy
);

    localparam int IW = idx_bits(NUM_CONSUMERS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] req_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;
    logic [NUM_CONSUMERS-1:0]                ready_q;

    srv_state_e           state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        g_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [CW-1:0]        cnt_q;

    logic [NUM_CONSUMERS-1:0] arb_gnt;
    logic [IW-1:0]            arb_idx;
    logic                     arb_hit;
    logic [ADDR_BITS-1:0]     arb_addr;

    assign req_addr            = consumer_read_address;
    assign consumer_read_data  = data_q;
    assign consumer_read_ready = ready_q;
    assign busy                = (state != IDLE);

    // A consumer already holding ready is still in its relay phase and must
    // not be picked again.
    rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
        .req (consumer_read_valid & ~ready_q),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .hit (arb_hit)
    );

    always_comb begin
        arb_addr = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++)
            if (arb_gnt[i]) arb_addr = arb_addr | req_addr[i];
    end

    // Host writes are independent of the FSM and of reset. A read capture in
    // the same edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_valid) mem[load_address] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        g_q    <= arb_idx;
                        addr_q <= arb_addr;
                        cnt_q  <= CW'(LATENCY - 1);
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        data_q[g_q]  <= mem[addr_q];
                        ready_q[g_q] <= 1'b1;
                        rr_ptr       <= (g_q == IW'(NUM_CONSUMERS - 1)) ? '0 : g_q + 1'b1;
                        state        <= RELAY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELAY: begin
                    // Leaving RELAY never grants in the same edge.
                    if (!consumer_read_valid[g_q]) begin
                        ready_q[g_q] <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_mem_server.sv
module tb_program_mem_server;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    // DUT A: 4 consumers, latency 2
    logic             a_rst;
    logic [3:0]       a_vld;
    logic [3:0][7:0]  a_addr;
    logic [3:0]       a_rdy;
    logic [3:0][15:0] a_data;
    logic             a_lv;
    logic [7:0]       a_la;
    logic [15:0]      a_ld;
    logic             a_busy;

    program_mem_server #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(16), .LATENCY(2)) dut_a (
        .clk                   (clk),
        .reset                 (a_rst),
        .consumer_read_valid   (a_vld),
        .consumer_read_address (a_addr),
        .consumer_read_ready   (a_rdy),
        .consumer_read_data    (a_data),
        .load_valid            (a_lv),
        .load_address          (a_la),
        .load_data             (a_ld),
        .busy                  (a_busy)
    );

    // DUT B: 1 consumer, latency 1
    logic        b_rst;
    logic [0:0]  b_vld;
    logic [7:0]  b_addr;
    logic [0:0]  b_rdy;
    logic [15:0] b_data;
    logic        b_lv;
    logic [7:0]  b_la;
    logic [15:0] b_ld;
    logic        b_busy;

    program_mem_server #(.NUM_CONSUMERS(1), .ADDR_BITS(8), .DATA_BITS(16), .LATENCY(1)) dut_b (
        .clk                   (clk),
        .reset                 (b_rst),
        .consumer_read_valid   (b_vld),
        .consumer_read_address (b_addr),
        .consumer_read_ready   (b_rdy),
        .consumer_read_data    (b_data),
        .load_valid            (b_lv),
        .load_address          (b_la),
        .load_data             (b_ld),
        .busy                  (b_busy)
    );

    typedef struct { logic [7:0] a; logic [15:0] d; } ld_t;
    typedef struct { int c; logic [7:0] a; int hold; logic [15:0] d; } vec_t;
    typedef struct { int c; logic [15:0] d; } exp_t;

    ld_t  lt[$];
    vec_t vt[$];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic a_load(input logic [7:0] a, input logic [15:0] d);
        a_lv = 1'b1; a_la = a; a_ld = d;
        @(negedge clk);
        a_lv = 1'b0;
    endtask

    // Single request from an idle server: ready must appear LATENCY+1
    // negedges after valid is raised, hold while valid is held, then clear.
    task automatic a_serve(input int c, input logic [7:0] ad, input int hold, input logic [15:0] exp);
        int k;
        a_addr[c] = ad;
        a_vld[c]  = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_rdy[c] && k < 20);
        chk("serve_latency", k, 3);
        chk("serve_data", a_data[c], exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("serve_hold_ready", a_rdy[c], 1);
            chk("serve_hold_data", a_data[c], exp);
        end
        a_vld[c] = 1'b0;
        @(negedge clk);
        chk("serve_clear_ready", a_rdy[c], 0);
        chk("serve_clear_busy", a_busy, 0);
        chk("serve_data_kept", a_data[c], exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, t, served, last;
        bit raised, nextreq;
        exp_t e;

        a_rst = 1'b1; a_vld = '0; a_addr = '0; a_lv = 1'b0; a_la = '0; a_ld = '0;
        b_rst = 1'b1; b_vld = '0; b_addr = '0; b_lv = 1'b0; b_la = '0; b_ld = '0;

        lt = '{'{8'h05, 16'hA1B2}, '{8'h06, 16'h1234}, '{8'hFF, 16'hF00D},
               '{8'h00, 16'h0001}, '{8'h80, 16'h8000},
               '{8'h10, 16'h5010}, '{8'h11, 16'h5011}, '{8'h12, 16'h5012},
               '{8'h13, 16'h5013}, '{8'h14, 16'h5014},
               '{8'h20, 16'h2222}, '{8'h30, 16'h1111},
               '{8'h41, 16'h6666}, '{8'h42, 16'h7777}};
        vt = '{'{0, 8'h05, 0, 16'hA1B2}, '{1, 8'h06, 1, 16'h1234},
               '{3, 8'hFF, 2, 16'hF00D}, '{2, 8'h00, 0, 16'h0001},
               '{0, 8'h80, 3, 16'h8000}};

        // Preload while held in reset.
        @(negedge clk);
        foreach (lt[i]) a_load(lt[i].a, lt[i].d);
        chk("reset_ready", a_rdy, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_data", (a_data == '0), 1);
        a_rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", a_busy, 0);

        // Table-driven single requests.
        foreach (vt[i]) a_serve(vt[i].c, vt[i].a, vt[i].hold, vt[i].d);

        // Round-robin: restart from rr_ptr=0.
        a_rst = 1'b1; @(negedge clk); a_rst = 1'b0;
        a_addr[0] = 8'h10; a_addr[1] = 8'h11; a_addr[3] = 8'h13;
        a_vld = 4'b1011;
        sbq = '{'{0, 16'h5010}, '{1, 16'h5011}, '{2, 16'h5012}, '{3, 16'h5013}, '{0, 16'h5014}};
        served = 0; raised = 0; t = 0;
        while (sbq.size() > 0 && t < 300) begin
            @(negedge clk); t++;
            if (served >= 1 && !raised) begin
                raised = 1;
                a_addr[2] = 8'h12; a_vld[2] = 1'b1;
                a_addr[0] = 8'h14; a_vld[0] = 1'b1;
            end
            for (int c = 0; c < 4; c++) begin
                if (a_vld[c] && a_rdy[c] && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rr_order", c, e.c);
                    chk("rr_data", a_data[c], e.d);
                    a_vld[c] = 1'b0;
                    served++;
                end
            end
        end
        chk("rr_pending", sbq.size(), 0);
        @(negedge clk);
        chk("rr_idle", a_busy, 0);

        // Consumer 2 holds valid 5 cycles past ready while consumer 1 waits.
        a_addr[2] = 8'h42; a_vld[2] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_rdy[2] && k < 20);
        chk("hold_latency", k, 3);
        chk("hold_data0", a_data[2], 16'h7777);
        a_addr[1] = 8'h41; a_vld[1] = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("hold_ready", a_rdy[2], 1);
            chk("hold_data", a_data[2], 16'h7777);
            chk("hold_other_wait", a_rdy[1], 0);
        end
        a_vld[2] = 1'b0;
        a_addr[2] = 8'h00;
        k = 0;
        @(negedge clk); k++;
        chk("hold_clear", a_rdy[2], 0);
        while (!a_rdy[1] && k < 20) begin @(negedge clk); k++; end
        chk("hold_next_grant_delay", k, 4);
        chk("hold_next_data", a_data[1], 16'h6666);
        chk("hold_data_kept", a_data[2], 16'h7777);
        a_vld[1] = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access.
        a_addr[0] = 8'h20; a_vld[0] = 1'b1;
        @(negedge clk);
        chk("midacc_busy", a_busy, 1);
        a_rst = 1'b1;
        @(negedge clk);
        chk("midacc_rst_ready", a_rdy, 0);
        chk("midacc_rst_busy", a_busy, 0);
        chk("midacc_rst_data", (a_data == '0), 1);
        a_rst = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_rdy[0] && k < 20);
        chk("midacc_rereq_latency", k, 3);
        chk("midacc_rereq_data", a_data[0], 16'h2222);
        a_vld[0] = 1'b0;
        @(negedge clk);

        // Load and read capture to the same address in the same edge.
        a_addr[0] = 8'h30; a_vld[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_lv = 1'b1; a_la = 8'h30; a_ld = 16'h000F;
        @(negedge clk);
        a_lv = 1'b0;
        chk("war_ready", a_rdy[0], 1);
        chk("war_old_data", a_data[0], 16'h1111);
        a_vld[0] = 1'b0;
        @(negedge clk);
        a_serve(0, 8'h30, 0, 16'h000F);

        // Single consumer, latency 1: back-to-back fetches.
        b_lv = 1'b1; b_la = 8'h00; b_ld = 16'hBEEF;
        @(negedge clk);
        b_la = 8'h01; b_ld = 16'hCAFE;
        @(negedge clk);
        b_lv = 1'b0;
        chk("b_reset_ready", b_rdy, 0);
        chk("b_reset_busy", b_busy, 0);
        b_rst = 1'b0;
        sbq = '{'{0, 16'hBEEF}, '{0, 16'hCAFE}};
        b_addr = 8'h00; b_vld = 1'b1;
        served = 0; last = 0; nextreq = 0; t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(negedge clk); t++;
            if (b_vld[0] && b_rdy[0]) begin
                e = sbq.pop_front();
                chk("b_data", b_data, e.d);
                if (served > 0) chk("b_spacing", cyc - last, 3);
                last = cyc;
                b_vld = 1'b0;
                served++;
                nextreq = 1;
            end else if (nextreq && !b_rdy[0]) begin
                nextreq = 0;
                b_addr = 8'(served);
                b_vld = 1'b1;
            end
        end
        chk("b_pending", sbq.size(), 0);
        @(negedge clk);
        chk("b_idle", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
